bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the binary input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 5, giving the number of BCD output digits; DIGITS*4 SHALL hold 2^WIDTH-1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  conversion enable; new conversion starts only while high.
REQ-006 bin_in  input  WIDTH  unsigned binary value to display (the selected operand/product value).
REQ-007 bcd_out  output  DIGITS*4  registered packed BCD result; digit 0 (units) in bits [3:0].
REQ-008 valid  output  1  registered one-cycle pulse marking a bcd_out update.
REQ-009 busy  output  1  high while a conversion is in progress (SHIFT or DONE state).

Function
REQ-010 The block SHALL implement a shift-and-add-3 (double-dabble) converter with states IDLE, SHIFT and DONE.
REQ-011 IDLE with en=1 at a rising edge: SHALL capture bin_in into a WIDTH-bit shift register, clear the DIGITS*4 scratch register, clear the iteration counter and go to SHIFT.
REQ-012 IDLE with en=0: SHALL stay in IDLE, bcd_out held, valid=0.
REQ-013 SHIFT, each edge: each scratch digit >=5 SHALL get +3 (4-bit add, no carry between digits), then {scratch, shift register} SHALL shift left one bit, shift-register MSB entering scratch bit 0.
REQ-014 SHIFT SHALL last exactly WIDTH edges (counter 0..WIDTH-1); at counter = WIDTH-1 it SHALL go to DONE.
REQ-015 DONE, single edge: bcd_out SHALL load scratch, valid SHALL be set to 1 for exactly one cycle, state SHALL go to IDLE.
REQ-016 Latency: for capture at edge E0, bcd_out and valid SHALL update at edge E0+WIDTH+1 (E17 at defaults); earliest next capture is E0+WIDTH+2; repetition period with en held high is WIDTH+2 cycles (18).
REQ-017 bin_in changes after capture SHALL NOT affect the conversion in progress; the new value is used at the next IDLE capture.
REQ-018 en deasserted during SHIFT or DONE SHALL NOT abort the conversion; it only blocks the next capture.
REQ-019 bcd_out SHALL hold its previous value throughout a conversion (no intermediate digits visible, no display flicker).
REQ-020 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-021 Every bcd_out digit SHALL be in range 0-9; leading digits of small values SHALL be 0.
REQ-022 Counter width SHALL be ceil(log2(WIDTH)) bits minimum; no wrap SHALL occur within one conversion.

Reset
REQ-023 rst=1 SHALL immediately (asynchronously) force state=IDLE, bcd_out=0, valid=0, busy=0, and clear shift register, scratch and counter.
REQ-024 Reset asserted mid-conversion SHALL discard the partial result; bcd_out SHALL read 0 until a full conversion completes after release.
REQ-025 After rst deasserts, the first capture SHALL occur at the first rising edge with state IDLE and en=1.

Verification
REQ-026 rst then en=1, bin_in=0 -> at 17th edge after capture bcd_out=0x00000, valid one-cycle pulse, busy high for 17 cycles.
REQ-027 en=1, bin_in=16'd65535 -> bcd_out=0x65535; bin_in=16'd1234 -> bcd_out=0x01234; bin_in=16'd999 -> 0x00999.
REQ-028 capture bin_in=16'd42, change bin_in to 16'd7 on the 5th SHIFT cycle -> bcd_out=0x00042; next conversion gives 0x00007.
REQ-029 en held high, bin_in=16'd100 constant -> valid pulses every 18 cycles, bcd_out stable at 0x00100, no intermediate values.
REQ-030 bcd_out=0x00042, start conversion of 16'd500, assert rst at SHIFT cycle 8 -> bcd_out=0, state IDLE; after release and en=1 -> 0x00500 after 17 edges.
REQ-031 en dropped to 0 on 3rd SHIFT cycle with bin_in=16'd250 -> conversion completes with 0x00250, then no further valid pulses while en=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// The result register only updates when a conversion completes, so a display driven from it never flickers.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  valid,
    output logic                  busy
);

    // state | meaning
    // IDLE  | waiting for en; bcd_out holds last result
    // SHIFT | one add-3/shift step per clock, WIDTH steps
    // DONE  | publish scratch to bcd_out, pulse valid

    localparam int unsigned DW = DIGITS * 4;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [DW-1:0]    scratch;
    logic [DW-1:0]    scratch_adj;
    logic [CW-1:0]    cnt;
    logic             capture, shifting, finishing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        capture   = (state == IDLE) && en;
        shifting  = (state == SHIFT);
        finishing = (state == DONE);
    end

    // Per-digit +3 correction; digits never carry into each other.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= finishing;
            if (capture) begin
                shift_reg <= bin_in;
                scratch   <= '0;
                cnt       <= '0;
            end else if (shifting) begin
                scratch   <= {scratch_adj[DW-2:0], shift_reg[WIDTH-1]};
                shift_reg <= shift_reg << 1;
                // Hold at the last count so a power-of-two WIDTH never wraps.
                if (cnt != CNT_LAST)
                    cnt <= cnt + 1'b1;
            end
            if (finishing)
                bcd_out <= scratch;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: scoreboard of expected results and due cycles,
// a vector table plus hand-written multi-cycle sequences.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] bin_in = '0;
    logic [19:0] bcd_out;
    logic        valid;
    logic        busy;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .en(en), .bin_in(bin_in),
        .bcd_out(bcd_out), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] bin; logic [19:0] exp; } vec_t;
    typedef struct { logic [19:0] exp; int due; } sb_t;

    sb_t         sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [19:0] bcd_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (!rst) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_valid: got valid=1 bcd=%0h, expected no pulse", bcd_out);
                end else begin
                    e = sb.pop_front();
                    check("bcd_out", bcd_out, e.exp);
                    check("latency", cyc, e.due);
                    for (int d = 0; d < 5; d++)
                        if (bcd_out[d*4 +: 4] > 4'd9) begin
                            n_err++;
                            $display("FAIL digit_range: got digit %0d=%0h, expected <=9", d, bcd_out[d*4 +: 4]);
                        end
                end
            end else if (bcd_out !== bcd_prev) begin
                n_err++;
                $display("FAIL bcd_hold: got %0h without valid, expected %0h", bcd_out, bcd_prev);
            end
        end
        bcd_prev = bcd_out;
    end

    // Called at a negedge; the following rising edge captures.
    task automatic start(input logic [15:0] b, input logic [19:0] e);
        int t = 0;
        while (busy && t < 100) begin @(negedge clk); t++; end
        if (busy) begin
            n_err++;
            $display("FAIL idle_wait: got busy=1, expected 0");
        end
        bin_in = b;
        en = 1'b1;
        sb.push_back('{exp: e, due: cyc + 18});
    endtask

    task automatic wait_empty();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vec_t vecs[10];
        int   n;

        vecs[0] = '{16'd65535, 20'h65535};
        vecs[1] = '{16'd1234,  20'h01234};
        vecs[2] = '{16'd999,   20'h00999};
        vecs[3] = '{16'd1,     20'h00001};
        vecs[4] = '{16'd9,     20'h00009};
        vecs[5] = '{16'd10,    20'h00010};
        vecs[6] = '{16'd59999, 20'h59999};
        vecs[7] = '{16'd40960, 20'h40960};
        vecs[8] = '{16'd5,     20'h00005};
        vecs[9] = '{16'd32768, 20'h32768};

        #1;
        check("rst_bcd", bcd_out, 20'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero input, busy width
        start(16'd0, 20'h00000);
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        check("busy_cycles", n, 17);
        wait_empty();

        foreach (vecs[i]) begin
            start(vecs[i].bin, vecs[i].exp);
            @(negedge clk);
            en = 1'b0;
            wait_empty();
        end

        // bin_in changes on the 5th SHIFT cycle must not disturb the conversion
        start(16'd42, 20'h00042);
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        bin_in = 16'd7;
        wait_empty();
        start(16'd7, 20'h00007);
        @(negedge clk);
        en = 1'b0;
        wait_empty();

        // en held high: back-to-back conversions every 18 cycles
        start(16'd100, 20'h00100);
        sb.push_back('{exp: 20'h00100, due: sb[0].due + 18});
        sb.push_back('{exp: 20'h00100, due: sb[0].due + 36});
        wait_empty();
        en = 1'b0;

        // Reset during SHIFT discards the partial result
        start(16'd42, 20'h00042);
        @(negedge clk);
        en = 1'b0;
        wait_empty();
        start(16'd500, 20'h00500);
        @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_bcd", bcd_out, 20'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", valid, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        start(16'd500, 20'h00500);
        @(negedge clk);
        en = 1'b0;
        wait_empty();

        // en dropped on the 3rd SHIFT cycle, then stays low
        start(16'd250, 20'h00250);
        repeat (3) @(negedge clk);
        en = 1'b0;
        wait_empty();
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || valid) n++;
        end
        check("quiet_en_low", n, 0);
        check("final_bcd", bcd_out, 20'h00250);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
